vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares the single asynchronous-SRAM VRAM port between two requesters: the scanline renderer (read-only, latency-critical) and the MPU bus bridge (word read/write with byte enables).
- Sequences every access with fixed-length strobe timing and captures read data.
- Guarantees MPU forward progress with a grant-count starvation limit.
- Sits inside the ChronoCube core, between the renderer/MPU bridge and the core's active-high VRAM control outputs.

Parameters:
- ADDR_WIDTH, 16, VRAM word address width.
- DATA_WIDTH, 16, VRAM data width (two byte lanes).
- ACCESS_CYCLES, 2, clock cycles vram_en is held per access (1..7).
- MPU_MAX_WAIT, 4, consecutive renderer grants allowed while the MPU is pending (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ren_req  in  1  renderer read request, held until ren_done
- ren_addr  in  ADDR_WIDTH  renderer word address, stable while ren_req
- ren_done  out  1  one-cycle pulse; ren_rdata valid the same cycle and held until the next renderer completion
- ren_rdata  out  DATA_WIDTH  renderer read data
- mpu_req  in  1  MPU request, held until mpu_done
- mpu_wr  in  1  1 = write, 0 = read
- mpu_be  in  2  byte enables for writes (bit1 = high byte)
- mpu_addr  in  ADDR_WIDTH  MPU word address
- mpu_wdata  in  DATA_WIDTH  MPU write data
- mpu_done  out  1  one-cycle completion pulse
- mpu_rdata  out  DATA_WIDTH  MPU read data, valid at mpu_done and held
- owner  out  1  0 = renderer, 1 = MPU; owner of the current/last access
- vram_en  out  1  VRAM chip enable (active high)
- vram_rd  out  1  VRAM read strobe
- vram_wr  out  1  VRAM write strobe
- vram_be  out  2  VRAM byte enables
- vram_addr  out  ADDR_WIDTH  VRAM address
- vram_data_out  out  DATA_WIDTH  write data to the pad tristate
- vram_data_in  in  DATA_WIDTH  read data from the pads

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, state IDLE, wait counter 0.
- States:
  - IDLE: arbitrate. If no request, stay.
  - ACCESS: hold vram_* stable for ACCESS_CYCLES cycles, counted by a cycle counter.
  - RECOVER: vram_en/rd/wr = 0, pulse the winner's done, then go to IDLE.
- Arbitration, in IDLE only:
  - Renderer wins by default.
  - MPU wins if only mpu_req is high, or if both are high and wait_cnt == MPU_MAX_WAIT.
  - wait_cnt increments when the renderer is granted while mpu_req is high. It saturates at MPU_MAX_WAIT and clears when the MPU is granted.
- Latency: req sampled high in IDLE at cycle t → vram_en = 1 for cycles t+1 .. t+ACCESS_CYCLES → done at t+ACCESS_CYCLES+1. Back-to-back period is ACCESS_CYCLES+2.
- Re-requests: a requester still asserting req in the cycle after its done issues a new request. Requesters deassert on the done edge if they have no further work.
- Reads: vram_rd = 1, vram_wr = 0, vram_be = 2'b11. vram_data_in is sampled on the final ACCESS cycle into the winner's rdata register. The other requester's rdata is unchanged.
- Writes: vram_wr = 1, vram_rd = 0, vram_be = mpu_be, vram_data_out = mpu_wdata for all ACCESS cycles. vram_data_out is 0 otherwise.
- Write with mpu_be == 2'b00: occupies a full slot with vram_en/wr held 0 and still pulses mpu_done.
- Request capture: address, wr, be and wdata are captured at grant. Changes to inputs during ACCESS have no effect.
- Request dropped before done: illegal; the access completes and done still pulses.
- Exclusivity: ren_done and mpu_done are never high in the same cycle. vram_rd and vram_wr are never both high.
- owner updates at grant and holds through IDLE.
- Reset mid-access: the next cycle returns to IDLE with all strobes 0, no done pulse, and counters cleared.

Decomposition:
- Shared package: state enum (IDLE, ACCESS, RECOVER), owner encoding constants, and the VRAM address/data width constants shared with the renderer and MPU bridge.
- Single module, no sub-module.

Test Plan:
- Lone MPU write (addr 0x1234, data 0xBEEF, be 2'b10, ACCESS_CYCLES = 2) → vram_en/wr high for exactly 2 cycles with vram_be = 2'b10, mpu_done on cycle 3 after the request, ren_done stays 0.
- Lone renderer read of 0x0040, vram_data_in = 0xA5C3 on the final ACCESS cycle → ren_rdata = 0xA5C3 at ren_done; mpu_rdata unchanged.
- Both held continuously, MPU_MAX_WAIT = 4 → grant order R,R,R,R,M,R,R,R,R,M; owner matches the order; the period between completions is 4 cycles.
- MPU write with be = 2'b00 → vram_en stays 0 throughout, mpu_done pulses after 3 cycles.
- reset asserted during the 2nd ACCESS cycle → next cycle all vram_* = 0, no done pulse, a fresh ren_req is granted normally.
- Inputs (mpu_addr, mpu_wdata) changed mid-ACCESS → vram_addr and vram_data_out keep their grant-time values.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared types and constants for the VRAM arbiter and the blocks that talk to it.
// Holds the sequencer state encoding, owner encoding and VRAM bus widths.
package vram_arbiter_pkg;

  localparam int VRAM_ADDR_WIDTH = 16;
  localparam int VRAM_DATA_WIDTH = 16;

  localparam logic OWNER_REN = 1'b0;
  localparam logic OWNER_MPU = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } vram_state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Arbitrates the single async-SRAM VRAM port between the scanline renderer and the
// MPU bridge, sequencing fixed-length strobes and capturing read data.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH    = VRAM_DATA_WIDTH,
  parameter int ACCESS_CYCLES = 2,
  parameter int MPU_MAX_WAIT  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ren_req,
  input  logic [ADDR_WIDTH-1:0] ren_addr,
  output logic                  ren_done,
  output logic [DATA_WIDTH-1:0] ren_rdata,
  input  logic                  mpu_req,
  input  logic                  mpu_wr,
  input  logic [1:0]            mpu_be,
  input  logic [ADDR_WIDTH-1:0] mpu_addr,
  input  logic [DATA_WIDTH-1:0] mpu_wdata,
  output logic                  mpu_done,
  output logic [DATA_WIDTH-1:0] mpu_rdata,
  output logic                  owner,
  output logic                  vram_en,
  output logic                  vram_rd,
  output logic                  vram_wr,
  output logic [1:0]            vram_be,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_WIDTH-1:0] vram_data_out,
  input  logic [DATA_WIDTH-1:0] vram_data_in
);

  localparam logic [2:0] LAST_CYC = 3'(ACCESS_CYCLES - 1);
  localparam logic [3:0] MAX_WAIT = 4'(MPU_MAX_WAIT);

  vram_state_e           state_q, state_d;
  logic [2:0]            cyc_cnt_q, cyc_cnt_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic                  owner_q, owner_d;
  logic                  ren_done_q, ren_done_d;
  logic                  mpu_done_q, mpu_done_d;
  logic [DATA_WIDTH-1:0] ren_rdata_q, ren_rdata_d;
  logic [DATA_WIDTH-1:0] mpu_rdata_q, mpu_rdata_d;
  logic                  vram_en_q, vram_en_d;
  logic                  vram_rd_q, vram_rd_d;
  logic                  vram_wr_q, vram_wr_d;
  logic [1:0]            vram_be_q, vram_be_d;
  logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
  logic [DATA_WIDTH-1:0] vram_data_out_q, vram_data_out_d;
  logic                  grant_mpu;

  always_comb begin
    state_d         = state_q;
    cyc_cnt_d       = cyc_cnt_q;
    wait_cnt_d      = wait_cnt_q;
    op_wr_d         = op_wr_q;
    owner_d         = owner_q;
    ren_done_d      = 1'b0;
    mpu_done_d      = 1'b0;
    ren_rdata_d     = ren_rdata_q;
    mpu_rdata_d     = mpu_rdata_q;
    vram_en_d       = vram_en_q;
    vram_rd_d       = vram_rd_q;
    vram_wr_d       = vram_wr_q;
    vram_be_d       = vram_be_q;
    vram_addr_d     = vram_addr_q;
    vram_data_out_d = vram_data_out_q;
    grant_mpu       = mpu_req && (!ren_req || (wait_cnt_q == MAX_WAIT));

    case (state_q)
      IDLE: begin
        if (ren_req || mpu_req) begin
          state_d   = ACCESS;
          cyc_cnt_d = '0;
          if (grant_mpu) begin
            owner_d     = OWNER_MPU;
            wait_cnt_d  = '0;
            op_wr_d     = mpu_wr;
            vram_addr_d = mpu_addr;
            if (mpu_wr) begin
              // An all-zero byte mask still burns the slot but never strobes the SRAM.
              vram_be_d       = mpu_be;
              vram_en_d       = |mpu_be;
              vram_wr_d       = |mpu_be;
              vram_rd_d       = 1'b0;
              vram_data_out_d = (|mpu_be) ? mpu_wdata : '0;
            end else begin
              vram_be_d       = 2'b11;
              vram_en_d       = 1'b1;
              vram_wr_d       = 1'b0;
              vram_rd_d       = 1'b1;
              vram_data_out_d = '0;
            end
          end else begin
            owner_d         = OWNER_REN;
            op_wr_d         = 1'b0;
            vram_addr_d     = ren_addr;
            vram_be_d       = 2'b11;
            vram_en_d       = 1'b1;
            vram_wr_d       = 1'b0;
            vram_rd_d       = 1'b1;
            vram_data_out_d = '0;
            if (mpu_req && (wait_cnt_q != MAX_WAIT)) begin
              wait_cnt_d = wait_cnt_q + 4'd1;
            end
          end
        end
      end
      ACCESS: begin
        if (cyc_cnt_q == LAST_CYC) begin
          state_d         = RECOVER;
          vram_en_d       = 1'b0;
          vram_rd_d       = 1'b0;
          vram_wr_d       = 1'b0;
          vram_data_out_d = '0;
          ren_done_d      = (owner_q == OWNER_REN);
          mpu_done_d      = (owner_q == OWNER_MPU);
          if (!op_wr_q) begin
            if (owner_q == OWNER_MPU) mpu_rdata_d = vram_data_in;
            else                      ren_rdata_d = vram_data_in;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 3'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cyc_cnt_q       <= '0;
      wait_cnt_q      <= '0;
      op_wr_q         <= 1'b0;
      owner_q         <= OWNER_REN;
      ren_done_q      <= 1'b0;
      mpu_done_q      <= 1'b0;
      ren_rdata_q     <= '0;
      mpu_rdata_q     <= '0;
      vram_en_q       <= 1'b0;
      vram_rd_q       <= 1'b0;
      vram_wr_q       <= 1'b0;
      vram_be_q       <= '0;
      vram_addr_q     <= '0;
      vram_data_out_q <= '0;
    end else begin
      state_q         <= state_d;
      cyc_cnt_q       <= cyc_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      op_wr_q         <= op_wr_d;
      owner_q         <= owner_d;
      ren_done_q      <= ren_done_d;
      mpu_done_q      <= mpu_done_d;
      ren_rdata_q     <= ren_rdata_d;
      mpu_rdata_q     <= mpu_rdata_d;
      vram_en_q       <= vram_en_d;
      vram_rd_q       <= vram_rd_d;
      vram_wr_q       <= vram_wr_d;
      vram_be_q       <= vram_be_d;
      vram_addr_q     <= vram_addr_d;
      vram_data_out_q <= vram_data_out_d;
    end
  end

  assign ren_done      = ren_done_q;
  assign ren_rdata     = ren_rdata_q;
  assign mpu_done      = mpu_done_q;
  assign mpu_rdata     = mpu_rdata_q;
  assign owner         = owner_q;
  assign vram_en       = vram_en_q;
  assign vram_rd       = vram_rd_q;
  assign vram_wr       = vram_wr_q;
  assign vram_be       = vram_be_q;
  assign vram_addr     = vram_addr_q;
  assign vram_data_out = vram_data_out_q;

endmodule
